// File: rtl/ysyx_25040101_alu_pkg.sv
// Shared types and op-class helpers for the multi-cycle ALU and its iterative mul/div unit.
package ysyx_25040101_alu_pkg;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSll   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluSlt   = 4'd8,
        AluSltu  = 4'd9,
        AluMul   = 4'd10,
        AluMulhu = 4'd11,
        AluDiv   = 4'd12,
        AluDivu  = 4'd13,
        AluRem   = 4'd14,
        AluRemu  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    function automatic logic is_muldiv(alu_op_e op);
        return op inside {AluMul, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu};
    endfunction

    function automatic logic is_mul(alu_op_e op);
        return op inside {AluMul, AluMulhu};
    endfunction

    function automatic logic is_signed_div(alu_op_e op);
        return op inside {AluDiv, AluRem};
    endfunction

endpackage

// File: rtl/ysyx_25040101_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one 2*XLEN working register.
// done_o marks the last iteration; result_o is the sign-corrected value of that iteration.
module ysyx_25040101_muldiv_iter
    import ysyx_25040101_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CntW = $clog2(XLEN);

    alu_op_e           op_q, op_d, op_in;
    logic [2*XLEN-1:0] prod_q, prod_d, step;
    logic [XLEN-1:0]   b_q, b_d, a_mag, b_mag, quot, rem;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              run_q, run_d, negq_q, negq_d, negr_q, negr_d;
    logic              neg_a, neg_b;
    logic [XLEN:0]     add_sum, rem_sh, diff;

    assign op_in = alu_op_e'(op_i);

    // Multiply: low half holds the unconsumed multiplier, high half accumulates.
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    always_comb begin
        add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        rem_sh  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff    = rem_sh - {1'b0, b_q};
        if (is_mul(op_q)) begin
            step = prod_q[0] ? {add_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
        end else if (diff[XLEN]) begin
            step = {rem_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            step = {diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        neg_a  = is_signed_div(op_in) && a_i[XLEN-1];
        neg_b  = is_signed_div(op_in) && b_i[XLEN-1];
        a_mag  = neg_a ? ('0 - a_i) : a_i;
        b_mag  = neg_b ? ('0 - b_i) : b_i;
        op_d   = op_q;
        prod_d = prod_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        negq_d = negq_q;
        negr_d = negr_q;
        if (start_i) begin
            op_d   = op_in;
            prod_d = {{XLEN{1'b0}}, a_mag};
            b_d    = b_mag;
            cnt_d  = CntW'(XLEN - 1);
            run_d  = 1'b1;
            negq_d = neg_a ^ neg_b;
            negr_d = neg_a;
        end else if (run_q) begin
            prod_d = step;
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_comb begin
        quot = step[XLEN-1:0];
        rem  = step[2*XLEN-1:XLEN];
        case (op_q)
            AluMul:          result_o = step[XLEN-1:0];
            AluMulhu:        result_o = step[2*XLEN-1:XLEN];
            AluDiv, AluDivu: result_o = negq_q ? ('0 - quot) : quot;
            default:         result_o = negr_q ? ('0 - rem) : rem;
        endcase
    end

    assign done_o = run_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= AluAdd;
            prod_q <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            prod_q <= prod_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

endmodule

// File: rtl/ysyx_25040101_alu_mc.sv
// Multi-cycle integer ALU with valid/ready on both sides; single-cycle ops and division
// special cases retire in one cycle, MUL/DIV iterate in ysyx_25040101_muldiv_iter.
module ysyx_25040101_alu_mc
    import ysyx_25040101_alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] srca_data_i,
    input  logic [XLEN-1:0] srcb_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] alu_result_o
);
    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] sum, simple_res, md_res;
    logic [SHW-1:0]  shamt;
    alu_op_e         op;
    logic            accept, sub, b_zero, ovf, fast, md_start, md_done;

    assign op           = alu_op_e'(op_i);
    assign in_ready_o   = (state_q == StIdle) && !rst;
    assign accept       = in_valid_i && in_ready_o;
    assign out_valid_o  = (state_q == StDone);
    assign alu_result_o = result_q;

    always_comb begin
        sub    = (op == AluSub);
        sum    = srca_data_i + (srcb_data_i ^ {XLEN{sub}}) + {{(XLEN-1){1'b0}}, sub};
        shamt  = srcb_data_i[SHW-1:0];
        b_zero = (srcb_data_i == '0);
        ovf    = is_signed_div(op) && (srca_data_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (srcb_data_i == '1);
        fast   = is_muldiv(op) && !is_mul(op) && (b_zero || ovf);
        case (op)
            AluAdd, AluSub:  simple_res = sum;
            AluAnd:          simple_res = srca_data_i & srcb_data_i;
            AluOr:           simple_res = srca_data_i | srcb_data_i;
            AluXor:          simple_res = srca_data_i ^ srcb_data_i;
            AluSll:          simple_res = srca_data_i << shamt;
            AluSrl:          simple_res = srca_data_i >> shamt;
            AluSra:          simple_res = $signed(srca_data_i) >>> shamt;
            AluSlt:          simple_res = {{(XLEN-1){1'b0}},
                                           $signed(srca_data_i) < $signed(srcb_data_i)};
            AluSltu:         simple_res = {{(XLEN-1){1'b0}}, srca_data_i < srcb_data_i};
            // Only reached on the fast path: divide by zero or signed overflow.
            AluDiv, AluDivu: simple_res = b_zero ? '1 : srca_data_i;
            AluRem, AluRemu: simple_res = b_zero ? srca_data_i : '0;
            default:         simple_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        md_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_muldiv(op) && !fast) begin
                        md_start = 1'b1;
                        state_d  = StBusy;
                    end else begin
                        result_d = simple_res;
                        state_d  = StDone;
                    end
                end
            end
            StBusy: begin
                if (md_done) begin
                    result_d = md_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    ysyx_25040101_muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .op_i    (op_i),
        .a_i     (srca_data_i),
        .b_i     (srcb_data_i),
        .done_o  (md_done),
        .result_o(md_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/ysyx_25040101_alu_mc.md
# ysyx_25040101_alu_mc

Parametrised multi-cycle ALU: the next generation of the single-cycle add/sub ALU in the nebula-core execute stage. Performs full RV32/RV64-style integer ops on `XLEN`-bit operands, including iterative multiply and divide. Uses a valid/ready handshake on both sides so the EXU can stall on long ops. Single-cycle ops complete in one cycle; MUL/DIV ops take `XLEN+1` cycles.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; a power of two, ≥ 8.
- `SHW`, `$clog2(XLEN)`: shift-amount width (derived; not overridden).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, **synchronous, active-high**.
- `in_valid_i`  in  1  operands and op are valid.
- `in_ready_o`  out  1  unit can accept; equals `state==IDLE && !rst`.
- `op_i`  in  4  operation code (see Operation).
- `srca_data_i`  in  XLEN  operand A.
- `srcb_data_i`  in  XLEN  operand B.
- `out_valid_o`  out  1  `alu_result_o` is valid.
- `out_ready_i`  in  1  consumer takes the result.
- `alu_result_o`  out  XLEN  registered result.

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT, 9 SLTU.
  - 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned).
  - 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- ADD/SUB use one adder: `a + (b ^ {XLEN{sub}}) + sub`.
- SLT/SLTU return 0 or 1, zero-extended.
- Shifts use `srcb[SHW-1:0]`; upper bits of B are ignored.
- MUL/MULHU: shift-add over XLEN iterations into a 2·XLEN product register.
- DIV/DIVU/REM/REMU: restoring division over XLEN iterations.
  - Signed ops divide magnitudes, then correct signs: quotient sign = `a_sign ^ b_sign`; remainder sign = `a_sign`.
- Fast-path special cases complete with latency 1, like simple ops:
  - Divide by zero: quotient = all ones; remainder = A.
  - Signed overflow (A = 1<<(XLEN-1), B = all ones): DIV returns A; REM returns 0.
- FSM states:
  - IDLE: `in_ready_o`=1. On handshake, a simple op or fast-path case goes to DONE; MUL/DIV goes to BUSY with counter = XLEN-1.
  - BUSY: one iteration per cycle. When counter = 0, perform the final sign fix and go to DONE.
  - DONE: `out_valid_o`=1. On `out_ready_i`, go to IDLE.
- Operands and op are latched at the handshake; later changes to the inputs have no effect.

## Timing
- Reset values: state IDLE, `out_valid_o`=0, `alu_result_o`=0, counter 0, internal registers 0. `in_ready_o` reads 0 while `rst`=1.
- Latency is measured from the accept edge to the first cycle with `out_valid_o`=1:
  - Simple ops and fast paths: 1 cycle.
  - MUL/DIV: XLEN+1 cycles.
- The result holds stable while `out_valid_o`=1 and `out_ready_i`=0, with no limit on stall length.
- No overlap: `in_ready_o`=0 during BUSY and DONE. After a result is taken in DONE, the next op can be accepted no earlier than the following cycle (one bubble per op).
- `rst` in any state, including mid-BUSY: the op is aborted, no result is emitted, and all reset values apply on the next cycle.
- `in_valid_i`=0 in IDLE: no state change.
- `op_i` is fully decoded; no code is reserved.

## Structure
- Shared package `ysyx_25040101_alu_pkg` holds:
  - `alu_op_e` (the 4-bit op enum above).
  - `alu_state_e` (IDLE/BUSY/DONE).
  - Helpers `is_muldiv(op)` and `is_signed_div(op)`.
- One sub-module, `ysyx_25040101_muldiv_iter`:
  - Holds the shared product/remainder register, the counter and the sign fix-up.
  - Control: start/op/done.
- The top level holds the FSM, the single-cycle datapath and the output register.

## Test plan
- ADD 0x7FFFFFFF + 1 → 0x80000000. SUB 0 − 1 → 0xFFFFFFFF. Both with `out_valid_o` one cycle after accept.
- SRA 0x80000000 by B = 0x21 (shift 1) → 0xC0000000. SLT −1 vs 1 → 1; SLTU same operands → 0.
- MUL 0xFFFFFFFF × 2 → 0xFFFFFFFE; MULHU same operands → 0x00000001. `out_valid_o` at accept+33. `in_ready_o`=0 throughout.
- DIV −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 7 / 0 → 0xFFFFFFFF. DIV 0x80000000 / −1 → 0x80000000 at latency 1.
- Hold `out_ready_i`=0 for 10 cycles: result and `out_valid_o` stay stable. The next `in_valid_i` is not accepted until the cycle after the result is taken.
- Assert `rst` at BUSY iteration 15: the next cycle is IDLE with `out_valid_o`=0. A fresh ADD 3+4 then returns 7.
- Rerun all of the above with `XLEN`=64 (latency 65 for MUL/DIV).
